// File: rtl/rr_arb4_pkg.sv
// Shared constants and types for the rr_arb4 round-robin arbiter.
// The optional grant counters are enabled with RR_ARB4_GRANT_CNT_EN.
package rr_arb4_pkg;

  localparam int NR_REQ = 4;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  // Pointer advance relies on the natural 2-bit wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/MuxKey.sv
// Generic key/value selector: each LUT entry is {key, data}; the entry whose
// key matches drives out, and out is zero when no key matches.
module MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                 out,
  input  logic [KEY_LEN-1:0]                  key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) out = lut[i*PAIR_LEN +: DATA_LEN];
    end
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin winner finder: first valid requester searching
// upward from ptr with modulo-4 wrap.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NR_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]  ptr,
  output logic [PTR_W-1:0]  winner,
  output logic              any_valid
);

  logic [PTR_W-1:0] idx;

  // Walk from the farthest slot back to ptr so the nearest valid slot wins.
  always_comb begin
    winner = ptr;
    idx    = ptr;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (req_valid[idx]) winner = idx;
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter feeding a single-entry output buffer.
// Define RR_ARB4_GRANT_CNT_EN to add per-requester saturating grant counters.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int RST_PTR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NR_REQ-1:0]        req_valid,
  input  logic [NR_REQ*DATA_W-1:0] req_data,
  output logic [NR_REQ-1:0]        req_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [PTR_W-1:0]         out_src,
  input  logic                     out_ready
`ifdef RR_ARB4_GRANT_CNT_EN
  ,
  output logic [NR_REQ*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int PAIR_W = PTR_W + DATA_W;

  buf_state_t               state, state_nxt;
  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         winner;
  logic                     any_valid;
  logic                     can_accept;
  logic                     accept;
  logic [DATA_W-1:0]        sel_data;
  logic [NR_REQ*PAIR_W-1:0] lut;

  rr_pick4 u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_comb begin
    lut = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      lut[i*PAIR_W +: PAIR_W] = {PTR_W'(i), req_data[i*DATA_W +: DATA_W]};
    end
  end

  MuxKey #(
    .NR_KEY   (NR_REQ),
    .KEY_LEN  (PTR_W),
    .DATA_LEN (DATA_W)
  ) u_mux (
    .out (sel_data),
    .key (winner),
    .lut (lut)
  );

  // Holding rst_n low masks the grant so no word is consumed during reset.
  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign accept     = rst_n && can_accept && any_valid;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (accept)         state_nxt = FULL;
    else if (out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= PTR_W'(RST_PTR);
      out_data <= '0;
      out_src  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr      <= ptr_inc(winner);
        out_data <= sel_data;
        out_src  <= winner;
      end
    end
  end

`ifdef RR_ARB4_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [NR_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REQ; i++) cnt[i] <= '0;
    end else if (accept && (cnt[winner] != {CNT_W{1'b1}})) begin
      cnt[winner] <= cnt[winner] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NR_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule
